// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial BCD adder block.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary sum of two digits plus carry, corrected
// back into BCD range whenever it exceeds nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       carry
);

    logic [4:0] bin;

    assign bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    always_comb begin
        digit = bin[3:0];
        carry = 1'b0;
        if (bin > {1'b0, BCD_MAX}) begin
            digit = bin[3:0] + BCD_CORR;
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed BCD adder, least-significant digit first, one digit per clock.
// Define BCD_DIGIT_CHECK_EN to add a sticky err output flagging operand digits above nine.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_in,
    input  logic [4*DIGITS-1:0]   b_in,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   s_out,
    output logic                  cout
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t state, next_state;

    logic [4*DIGITS-1:0] a_reg, b_reg;
    logic [IDX_W-1:0]    idx;
    logic                carry_reg;
    logic [3:0]          a_dig, b_dig, sum_digit;
    logic                sum_carry;

    assign a_dig = a_reg[{idx, 2'b00} +: DIGIT_W];
    assign b_dig = b_reg[{idx, 2'b00} +: DIGIT_W];

    bcd_digit_add u_digit_add (
        .a     (a_dig),
        .b     (b_dig),
        .cin   (carry_reg),
        .digit (sum_digit),
        .carry (sum_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_ADD;
            ST_ADD:  if (idx == LAST_IDX) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // s_out is deliberately not cleared on start; each digit is overwritten as it is produced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            s_out     <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                ST_ADD: begin
                    s_out[{idx, 2'b00} +: DIGIT_W] <= sum_digit;
                    carry_reg <= sum_carry;
                    if (idx == LAST_IDX) begin
                        cout <= sum_carry;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    // Sticky across the whole operation so it is still valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            err <= 1'b0;
        end else if (state == ST_ADD && (a_dig > BCD_MAX || b_dig > BCD_MAX)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl with DIGITS=4.
// Checks of err are compiled only when BCD_DIGIT_CHECK_EN is defined.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [4*DIGITS-1:0] a_in, b_in;
    logic                cin;
    logic                busy, done;
    logic [4*DIGITS-1:0] s_out;
    logic                cout;
`ifdef BCD_DIGIT_CHECK_EN
    logic                err;
`endif

    int vectors = 0;
    int miscompares = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s_out (s_out),
        .cout  (cout)
`ifdef BCD_DIGIT_CHECK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one start pulse at a falling edge so it is sampled on the next rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
    endtask

    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] exp_s, input logic exp_cout);
        int cycles;
        int busy_cycles;
        bit got;
        applyStimulus(a, b, c);
        cycles = 0;
        busy_cycles = 0;
        got = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge clk);
            start = 1'b0;
            a_in  = 16'h0000;
            b_in  = 16'h0000;
            cycles++;
            if (busy) busy_cycles++;
            if (done) got = 1'b1;
        end
        checkOutput({tag, "_latency"}, cycles, 5);
        checkOutput({tag, "_busy_len"}, busy_cycles, 5);
        checkOutput({tag, "_s_out"}, s_out, exp_s);
        checkOutput({tag, "_cout"}, cout, exp_cout);
    endtask

    initial begin
        int done_count;
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_s_out", s_out, 16'h0000);
        checkOutput("rst_cout", cout, 1'b0);
        reset = 1'b0;

        runOp("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0);
        @(negedge clk);
        checkOutput("after_done_busy", busy, 1'b0);
        checkOutput("after_done_done", done, 1'b0);
        checkOutput("hold_s_out", s_out, 16'h6912);

        runOp("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);
        runOp("add_0000_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

        // Extra start requests mid-operation and in the done cycle must be ignored.
        applyStimulus(16'h2345, 16'h1111, 1'b0);
        done_count = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                checkOutput("ignore_done_cycle", n, 5);
                checkOutput("ignore_s_out", s_out, 16'h3456);
                checkOutput("ignore_cout", cout, 1'b0);
            end
            case (n)
                2: begin start = 1'b1; a_in = 16'h9999; b_in = 16'h9999; cin = 1'b1; end
                5: begin start = 1'b1; a_in = 16'h8888; b_in = 16'h8888; cin = 1'b1; end
                default: begin start = 1'b0; a_in = 16'h7777; b_in = 16'h7777; end
            endcase
        end
        checkOutput("ignore_done_count", done_count, 1);
        checkOutput("ignore_idle_busy", busy, 1'b0);
        checkOutput("ignore_hold_s_out", s_out, 16'h3456);

        runOp("add_0005_0005", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0);
        runOp("ripple_4999_5000", 16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1);
        runOp("nonbcd_000A", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0);
        runOp("add_0099_0001", 16'h0099, 16'h0001, 1'b0, 16'h0100, 1'b0);
        runOp("ripple_9999_0000_cin", 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1);

        // Reset during the second ADD cycle discards the partial result.
        applyStimulus(16'h5555, 16'h4444, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1'b1);
        checkOutput("pre_reset_s_out", s_out, 16'h0009);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_busy", busy, 1'b0);
        checkOutput("mid_reset_done", done, 1'b0);
        checkOutput("mid_reset_s_out", s_out, 16'h0000);
        checkOutput("mid_reset_cout", cout, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        runOp("post_reset_1111_2222", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
        runOp("chk_00A0_0001", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0);
        checkOutput("chk_err_set", err, 1'b1);
        runOp("chk_0001_0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        checkOutput("chk_err_clear", err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
